// File: rtl/byte_word_packer.sv
// -----------------------------------------------------------------------------
// byte_word_packer
//
// Collects a valid/ready byte stream into little-endian words of NUM_BYTES
// bytes and hands each finished word to a one-entry valid/ready output slot.
// A word can be closed early with in_last (the upper bytes read as zero).
// clr discards a partially collected word without touching the output slot.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   clr        synchronous discard of the partial word (blocks input that cycle)
//   in_valid   input byte valid
//   in_ready   input byte accepted when in_valid & in_ready
//   in_byte    input byte
//   in_last    marks in_byte as the final byte of the current word
//   out_valid  completed word available
//   out_ready  downstream takes the word when out_valid & out_ready
//   out_word   assembled word, byte 0 in the least significant bits
//   out_bytes  number of valid bytes in out_word (1..NUM_BYTES)
// -----------------------------------------------------------------------------
module byte_word_packer #(
  parameter  int NUM_BYTES = 4,
  parameter  int BYTE_W    = 8,
  localparam int WORD_W    = NUM_BYTES * BYTE_W,
  localparam int CNT_W     = $clog2(NUM_BYTES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [CNT_W-1:0]  out_bytes
);

  // Collection state: bytes [0, cnt) of the current word live in acc_q.
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // One-entry output slot.
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_word_q,  out_word_d;
  logic [CNT_W-1:0]  out_bytes_q, out_bytes_d;

  logic              accept;
  logic              completing;
  logic [WORD_W-1:0] merged;

  // The slot can take a new word in the same cycle it is drained, so input
  // only stalls while a word is held and downstream is not taking it.
  assign in_ready   = !clr && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign completing = accept && (in_last || (cnt_q == CNT_W'(NUM_BYTES - 1)));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_bytes_d = out_bytes_q;

    // Accumulator with the incoming byte dropped into slot cnt. Slots above
    // cnt are still zero because the accumulator is cleared on every word end.
    merged = acc_q;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (cnt_q == CNT_W'(i)) merged[i*BYTE_W +: BYTE_W] = in_byte;
    end

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (clr) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (completing) begin
        // A completing accept overrides the drain above: no bubble.
        out_word_d  = merged;
        out_bytes_d = cnt_q + CNT_W'(1);
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        acc_d = merged;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order; blocking here would race.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the accumulator is a plain register, not a memory, so it is
      // reset along with everything else; stale bytes must never leak out.
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_bytes_q <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_bytes_q <= out_bytes_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign out_bytes = out_bytes_q;

endmodule

// File: tb/tb_byte_word_packer.sv
// -----------------------------------------------------------------------------
// tb_byte_word_packer
//
// Self-checking bench for byte_word_packer (NUM_BYTES=4, BYTE_W=8). A model
// keeps the partial word as a queue of bytes and the output slot as plain
// variables; outputs are compared against it every cycle, with a few literal
// expectations from hand-worked sequences on top.
// -----------------------------------------------------------------------------
module tb_byte_word_packer;

  localparam int NB     = 4;
  localparam int BW     = 8;
  localparam int WORD_W = NB * BW;
  localparam int CNT_W  = $clog2(NB + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              clr;
  logic              in_valid;
  logic              in_ready;
  logic [BW-1:0]     in_byte;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_word;
  logic [CNT_W-1:0]  out_bytes;

  byte_word_packer #(.NUM_BYTES(NB), .BYTE_W(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_byte   (in_byte),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_bytes (out_bytes)
  );

  always #5 clk = ~clk;

  // Downstream load-enabled register fed by the packer.
  logic [WORD_W-1:0] dq = '0;
  always @(posedge clk) if (out_valid && out_ready) dq <= out_word;

  int errors = 0;
  int checks = 0;

  // Behavioural model.
  logic [BW-1:0]     part[$];
  logic              m_valid;
  logic [WORD_W-1:0] m_word;
  int                m_bytes;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("out_word",  64'(out_word),  64'(m_word));
    check("out_bytes", 64'(out_bytes), 64'(m_bytes));
  endtask

  task automatic model_reset();
    part.delete();
    m_valid = 1'b0;
    m_word  = '0;
    m_bytes = 0;
  endtask

  // One clock cycle: drive inputs, check in_ready, advance the model across
  // the edge, then check the registered outputs just after it.
  task automatic cyc(input logic v, input logic [BW-1:0] b, input logic l,
                     input logic c, input logic r);
    logic              exp_rdy;
    logic              fire;
    logic [WORD_W-1:0] w;
    in_valid  = v;
    in_byte   = b;
    in_last   = l;
    clr       = c;
    out_ready = r;
    #1;
    exp_rdy = !c && (!m_valid || r);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    fire = v && exp_rdy;
    @(posedge clk);
    if (m_valid && r) m_valid = 1'b0;
    if (c) begin
      part.delete();
    end else if (fire) begin
      part.push_back(b);
      if (part.size() == NB || l) begin
        w = '0;
        foreach (part[i]) w = w | (WORD_W'(part[i]) << (BW * i));
        m_word  = w;
        m_bytes = part.size();
        m_valid = 1'b1;
        part.delete();
      end
    end
    #1;
    check_outputs();
  endtask

  // Assert rst between edges; outputs must clear before the next edge.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("async_valid", 64'(out_valid), 64'(0));
    check("async_word",  64'(out_word),  64'(0));
    check("async_bytes", 64'(out_bytes), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_byte = '0; in_last = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_word",  64'(out_word),  64'(0));
    check("rst_bytes", 64'(out_bytes), 64'(0));
    check("rst_ready", 64'(in_ready),  64'(1));

    // Full word.
    cyc(1, 8'h78, 0, 0, 1);
    cyc(1, 8'h56, 0, 0, 1);
    cyc(1, 8'h34, 0, 0, 1);
    cyc(1, 8'h12, 0, 0, 1);
    check("full_word",  64'(out_word),  64'h12345678);
    check("full_bytes", 64'(out_bytes), 64'd4);
    cyc(0, 8'h00, 0, 0, 1);
    check("downstream_q", 64'(dq), 64'h12345678);

    // Backpressure, then release with a byte accepted in the same cycle.
    repeat (4) cyc(1, 8'hA5, 0, 0, 0);
    repeat (3) cyc(1, 8'hEF, 0, 0, 0);
    check("bp_word", 64'(out_word), 64'hA5A5A5A5);
    cyc(1, 8'hEF, 0, 0, 1);
    check("bp_drained", 64'(dq), 64'hA5A5A5A5);

    // Early last, then a full word with no residue.
    cyc(1, 8'hBE, 1, 0, 1);
    check("early_word",  64'(out_word),  64'h0000BEEF);
    check("early_bytes", 64'(out_bytes), 64'd2);
    cyc(1, 8'h11, 0, 0, 1);
    cyc(1, 8'h22, 0, 0, 1);
    cyc(1, 8'h33, 0, 0, 1);
    cyc(1, 8'h44, 0, 0, 1);
    check("after_early", 64'(out_word), 64'h44332211);

    // Clear discards a partial word.
    cyc(1, 8'hAA, 0, 0, 1);
    cyc(1, 8'hBB, 0, 0, 1);
    cyc(1, 8'hCC, 0, 1, 1);
    for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 0, 0, 1);
    check("clr_word",  64'(out_word),  64'h04030201);
    check("clr_bytes", 64'(out_bytes), 64'd4);

    // Back-to-back words with no gap.
    for (int i = 0; i < 8; i++) begin
      cyc(1, 8'(i), 0, 0, 1);
      if (i == 3) check("b2b_word0", 64'(out_word), 64'h03020100);
      if (i == 7) check("b2b_word1", 64'(out_word), 64'h07060504);
    end
    check("b2b_valid", 64'(out_valid), 64'd1);

    // Async reset mid-word with a pending word.
    cyc(1, 8'h08, 0, 0, 0);
    cyc(1, 8'h09, 0, 0, 0);
    async_reset();
    cyc(0, 8'h00, 0, 0, 1);
    check("post_rst_valid", 64'(out_valid), 64'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) async_reset();
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
          $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
